// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source result FIFOs feeding CDB_COUNT registered
// broadcast ports under rotating-priority arbitration.
package cdb_arbiter_pkg;
  typedef struct packed {
    logic [5:0]  rob_id;
    logic [31:0] value;
    logic        exc;
  } cdb_info_t;
endpackage

module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned SRC_CNT    = 4,
  parameter int unsigned CDB_COUNT  = 2,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic      [SRC_CNT-1:0]        src_valid_i,
  input  cdb_info_t [SRC_CNT-1:0]        src_data_i,
  output logic      [SRC_CNT-1:0]        src_ready_o,
  output cdb_info_t [CDB_COUNT-1:0]      cdb_o,
  output logic      [CDB_COUNT-1:0]      cdb_valid_o,
  input  logic                           cdb_ready_i
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = (SRC_CNT > 1) ? $clog2(SRC_CNT) : 1;

  cdb_info_t               mem_q    [SRC_CNT][FIFO_DEPTH];
  logic      [AW-1:0]      rd_ptr_q [SRC_CNT];
  logic      [AW-1:0]      wr_ptr_q [SRC_CNT];
  logic      [CW-1:0]      count_q  [SRC_CNT];
  logic      [SW-1:0]      rr_q, rr_d;
  cdb_info_t [CDB_COUNT-1:0] cdb_d;
  logic      [CDB_COUNT-1:0] cdb_valid_d;
  logic      [SRC_CNT-1:0] push, pop, nonempty;
  logic                    adv;

  // A stalled broadcast only blocks when something is actually being presented.
  assign adv = cdb_ready_i | ~(|cdb_valid_o);

  always_comb begin
    for (int s = 0; s < SRC_CNT; s++) begin
      src_ready_o[s] = count_q[s] < CW'(FIFO_DEPTH);
      nonempty[s]    = count_q[s] != '0;
      push[s]        = src_valid_i[s] & src_ready_o[s] & ~flush;
    end
  end

  always_comb begin
    int unsigned n_grant;
    int unsigned idx;
    n_grant     = 0;
    idx         = 0;
    pop         = '0;
    rr_d        = rr_q;
    cdb_d       = '0;
    cdb_valid_d = '0;
    for (int unsigned i = 0; i < SRC_CNT; i++) begin
      idx = (32'(rr_q) + i) % SRC_CNT;
      if (nonempty[idx] && n_grant < CDB_COUNT) begin
        cdb_d[n_grant]       = mem_q[idx][rd_ptr_q[idx]];
        cdb_valid_d[n_grant] = 1'b1;
        pop[idx]             = adv & ~flush;
        rr_d                 = SW'((idx + 1) % SRC_CNT);
        n_grant              = n_grant + 1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SRC_CNT; s++) begin
        rd_ptr_q[s] <= '0;
        wr_ptr_q[s] <= '0;
        count_q[s]  <= '0;
      end
      rr_q        <= '0;
      cdb_o       <= '0;
      cdb_valid_o <= '0;
    end else if (flush) begin
      for (int s = 0; s < SRC_CNT; s++) begin
        rd_ptr_q[s] <= '0;
        wr_ptr_q[s] <= '0;
        count_q[s]  <= '0;
      end
      rr_q        <= '0;
      cdb_o       <= '0;
      cdb_valid_o <= '0;
    end else begin
      for (int s = 0; s < SRC_CNT; s++) begin
        if (push[s]) wr_ptr_q[s] <= wr_ptr_q[s] + 1'b1;
        if (pop[s])  rd_ptr_q[s] <= rd_ptr_q[s] + 1'b1;
        count_q[s] <= count_q[s] + CW'(push[s]) - CW'(pop[s]);
      end
      if (adv) begin
        rr_q        <= rr_d;
        cdb_o       <= cdb_d;
        cdb_valid_o <= cdb_valid_d;
      end
    end
  end

  // Storage needs no reset: entries are only read when count marks them valid.
  always_ff @(posedge clk) begin
    for (int s = 0; s < SRC_CNT; s++) begin
      if (push[s]) mem_q[s][wr_ptr_q[s]] <= src_data_i[s];
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: stimulus pushes expected broadcasts into per-port
// queues, a negedge monitor pops and compares every accepted broadcast.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush;
  logic      [3:0]       src_valid;
  cdb_info_t [3:0]       src_data;
  logic      [3:0]       src_ready;
  cdb_info_t [1:0]       cdb;
  logic      [1:0]       cdb_valid;
  logic                  cdb_ready;

  int checks = 0;
  int passes = 0;
  int seen   = 0;
  int exp_total = 0;
  cdb_info_t q0[$];
  cdb_info_t q1[$];
  cdb_info_t held;

  cdb_arbiter #(
    .SRC_CNT   (4),
    .CDB_COUNT (2),
    .FIFO_DEPTH(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .src_valid_i (src_valid),
    .src_data_i  (src_data),
    .src_ready_o (src_ready),
    .cdb_o       (cdb),
    .cdb_valid_o (cdb_valid),
    .cdb_ready_i (cdb_ready)
  );

  always #5 clk = ~clk;

  function automatic cdb_info_t mk(input int rob);
    cdb_info_t r;
    r.rob_id = 6'(rob);
    r.value  = 32'(rob * 1000 + 7);
    r.exc    = rob[0];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic expect_out(input int port, input int rob);
    if (port == 0) q0.push_back(mk(rob));
    else           q1.push_back(mk(rob));
    exp_total++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a broadcast counts when valid and accepted.
  always @(negedge clk) begin
    if (!rst && cdb_ready) begin
      if (cdb_valid[0]) begin
        seen++;
        if (q0.size() == 0) begin
          checks++;
          $display("FAIL port0 unexpected: got %h, expected no broadcast", cdb[0]);
        end else chk("port0 data", 64'(cdb[0]), 64'(q0.pop_front()));
      end
      if (cdb_valid[1]) begin
        seen++;
        if (q1.size() == 0) begin
          checks++;
          $display("FAIL port1 unexpected: got %h, expected no broadcast", cdb[1]);
        end else chk("port1 data", 64'(cdb[1]), 64'(q1.pop_front()));
      end
    end
  end

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    src_valid = '0;
    src_data  = '0;
    cdb_ready = 1'b1;
    #3;
    chk("reset valid", 64'(cdb_valid), 64'(2'b00));
    chk("reset data", 64'(cdb), 64'(0));
    chk("reset ready", 64'(src_ready), 64'(4'b1111));
    #10 rst = 1'b0;
    tick;
    tick;
    tick;
    chk("idle valid", 64'(cdb_valid), 64'(2'b00));

    // Single source, back-to-back
    src_valid[0] = 1'b1; src_data[0] = mk(5); expect_out(0, 5);
    tick;
    src_data[0] = mk(6); expect_out(0, 6);
    tick;
    src_valid = '0;
    chk("single valid 1", 64'(cdb_valid), 64'(2'b01));
    chk("single rob 5", 64'(cdb[0].rob_id), 64'(5));
    tick;
    chk("single valid 2", 64'(cdb_valid), 64'(2'b01));
    chk("single rob 6", 64'(cdb[0].rob_id), 64'(6));
    tick;
    chk("single drained", 64'(cdb_valid), 64'(2'b00));

    // Flush brings rr_ptr back to 0 before the round-robin test
    flush = 1'b1;
    tick;
    flush = 1'b0;

    src_valid = 4'b1111;
    for (int s = 0; s < 4; s++) src_data[s] = mk(10 + s);
    expect_out(0, 10); expect_out(1, 11); expect_out(0, 12); expect_out(1, 13);
    tick;
    src_valid = '0;
    tick;
    chk("rr first valid", 64'(cdb_valid), 64'(2'b11));
    chk("rr first port1", 64'(cdb[1].rob_id), 64'(11));
    tick;
    chk("rr second port0", 64'(cdb[0].rob_id), 64'(12));
    tick;
    // rr_ptr must be 0 again: src 0 ahead of src 3
    src_valid = 4'b1001; src_data[0] = mk(20); src_data[3] = mk(23);
    expect_out(0, 20); expect_out(1, 23);
    tick;
    src_valid = '0;
    tick;
    chk("rr wrap port1", 64'(cdb[1].rob_id), 64'(23));
    tick;

    // Backpressure and full FIFO
    cdb_ready = 1'b0;
    src_valid[0] = 1'b1; src_data[0] = mk(30); expect_out(0, 30);
    tick;
    src_valid = '0;
    tick;
    chk("stall valid", 64'(cdb_valid), 64'(2'b01));
    held = cdb[0];
    src_valid[1] = 1'b1; src_data[1] = mk(31); expect_out(0, 31);
    tick;
    src_data[1] = mk(32); expect_out(0, 32);
    tick;
    chk("full ready", 64'(src_ready), 64'(4'b1101));
    src_data[1] = mk(33);
    tick;
    chk("refused ready", 64'(src_ready), 64'(4'b1101));
    chk("stall hold data", 64'(cdb[0]), 64'(held));
    chk("stall hold valid", 64'(cdb_valid), 64'(2'b01));
    cdb_ready = 1'b1;
    src_data[1] = mk(34);
    #1;
    chk("full pop ready", 64'(src_ready[1]), 64'(1'b0));
    tick;
    src_data[1] = mk(35); expect_out(0, 35);
    chk("after pop ready", 64'(src_ready[1]), 64'(1'b1));
    tick;
    src_valid = '0;
    tick;
    chk("pushpop order", 64'(cdb[0].rob_id), 64'(35));
    tick;
    chk("bp drained", 64'(cdb_valid), 64'(2'b00));
    chk("bp ready", 64'(src_ready), 64'(4'b1111));

    // Flush with three non-empty FIFOs and a push in flight
    cdb_ready = 1'b0;
    src_valid = 4'b0111;
    for (int s = 0; s < 3; s++) src_data[s] = mk(40 + s);
    tick;
    for (int s = 0; s < 3; s++) src_data[s] = mk(43 + s);
    tick;
    src_valid = 4'b1000; src_data[3] = mk(46);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    src_valid = '0;
    chk("flush valid", 64'(cdb_valid), 64'(2'b00));
    chk("flush data", 64'(cdb), 64'(0));
    chk("flush ready", 64'(src_ready), 64'(4'b1111));
    cdb_ready = 1'b1;
    src_valid = 4'b1001; src_data[0] = mk(51); src_data[3] = mk(50);
    expect_out(0, 51); expect_out(1, 50);
    tick;
    src_valid = '0;
    tick;
    chk("flush rr port1", 64'(cdb[1].rob_id), 64'(50));
    tick;
    tick;

    // Asynchronous reset mid-cycle with data buffered and a stalled broadcast
    cdb_ready = 1'b0;
    src_valid = 4'b0011; src_data[0] = mk(60); src_data[1] = mk(61);
    tick;
    src_data[0] = mk(62); src_data[1] = mk(63);
    tick;
    src_valid = '0;
    chk("pre-reset valid", 64'(cdb_valid), 64'(2'b11));
    #2 rst = 1'b1;
    #1;
    chk("async reset valid", 64'(cdb_valid), 64'(2'b00));
    chk("async reset data", 64'(cdb), 64'(0));
    #3 rst = 1'b0;
    chk("post-reset ready", 64'(src_ready), 64'(4'b1111));
    cdb_ready = 1'b1;
    tick;
    tick;
    tick;
    chk("post-reset idle", 64'(cdb_valid), 64'(2'b00));

    chk("port0 queue empty", 64'(q0.size()), 64'(0));
    chk("port1 queue empty", 64'(q1.size()), 64'(0));
    chk("broadcast count", 64'(seen), 64'(exp_total));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Downstream of every execution-unit issue queue (ALU, MDU, LSU IQs); consumes each unit's registered result plus its valid/ready handshake.
- Buffers each source's results in a small per-source FIFO.
- Each cycle, round-robin arbitrates up to CDB_COUNT results onto registered CDB broadcast ports, which feed the ROB and IQ operand forwarding.

Parameters:
- SRC_CNT, 4, number of execution-unit result sources.
- CDB_COUNT, 2, number of CDB broadcast ports.
- FIFO_DEPTH, 2, entries per source FIFO; power of two, at least 2.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipeline flush.
- src_valid_i  in  SRC_CNT  result valid per source.
- src_data_i  in  cdb_info_t[SRC_CNT]  result payload per source.
- src_ready_o  out  SRC_CNT  source FIFO can accept this cycle.
- cdb_o  out  cdb_info_t[CDB_COUNT]  broadcast payload.
- cdb_valid_o  out  CDB_COUNT  broadcast valid.
- cdb_ready_i  in  1  consumer accepts the current broadcast (global stall when 0).

Behaviour:
- Reset (rst=1, asynchronous): all FIFOs empty, rr_ptr=0, cdb_valid_o='0, cdb_o='0. src_ready_o='1 once FIFOs are empty.
- Flush: same effect as reset, applied at the next rising edge. A push or pop in the same cycle as flush is discarded.
- Per-source FIFO:
  - count width $clog2(FIFO_DEPTH)+1; read/write pointers wrap modulo FIFO_DEPTH.
  - src_ready_o[s] = (count[s] < FIFO_DEPTH). It is a function of registered state only, never of src_valid_i or of a pop in the same cycle.
  - Push when src_valid_i[s] & src_ready_o[s].
  - A full FIFO refuses a push even if it pops in the same cycle.
  - A simultaneous push and pop on a non-full FIFO leaves count unchanged.
- Advance condition: adv = cdb_ready_i | ~(|cdb_valid_o). When adv=0, the output registers, FIFOs (pop side) and rr_ptr hold. Pushes still occur.
- Arbitration (combinational, evaluated when adv=1):
  - Scan sources in order rr_ptr, rr_ptr+1, ... (mod SRC_CNT).
  - Grant the first min(CDB_COUNT, number non-empty) non-empty FIFOs.
  - The k-th grant drives CDB port k.
- Output registers on adv:
  - cdb_o[k] <= head of the k-th granted FIFO; cdb_valid_o[k] <= 1.
  - Ungranted ports get valid 0 and payload '0.
  - Granted FIFOs pop.
- rr_ptr update on adv:
  - With at least one grant: rr_ptr <= (index of last granted source + 1) mod SRC_CNT.
  - With no grant: rr_ptr unchanged.
- Latency: a push at edge N has its head visible in cycle N+1 and can appear on cdb_o from edge N+1. Minimum 1 cycle from push to broadcast; throughput is CDB_COUNT results per cycle.
- Fairness: a non-empty source waits at most ceil(SRC_CNT/CDB_COUNT)-1 advancing cycles before it is granted.
- Payload passes through unmodified; no field decoding.
- At most one grant per source per cycle, even if its FIFO holds more than one entry.

Test Plan:
- Reset/idle: assert rst mid-cycle with FIFOs holding data → cdb_valid_o=0 immediately and src_ready_o=4'b1111 after release. Release with no stimulus → outputs stay 0.
- Single source, back-to-back: src 0 pushes rob_id 5, then 6 on consecutive cycles with cdb_ready_i=1 → cdb_o[0].rob_id=5 at edge N+1 and 6 at edge N+2; cdb_valid_o=2'b01 both cycles.
- Round-robin: all 4 sources push one entry in the same cycle, rr_ptr=0 → first broadcast grants src 0,1 on ports 0,1; next grants src 2,3; rr_ptr then equals 0.
- Backpressure/full: hold cdb_ready_i=0 with valid outputs present, and src 1 pushes 3 times → src_ready_o[1]=0 after 2 pushes, the third push is refused, and cdb_o holds stable. Release → the 2 queued entries drain in order on later cycles.
- Push+pop same cycle: FIFO count=1 with simultaneous pop and push → count stays 1 and order is preserved. Full FIFO with pop → src_ready_o still 0 that cycle.
- Flush: flush=1 while 3 FIFOs are non-empty and a push is in flight → next cycle all counts 0, cdb_valid_o=0, rr_ptr=0, and the in-flight push is lost.
